// File: rtl/obj_bus_master.sv
// Object-bus initiator: turns single-byte read/write commands into strobed
// OBJCS/PDS bus cycles, waits for ODTAC and returns one response per command.
module obj_bus_master #(
  parameter int unsigned SETUP_CYC   = 2,
  parameter int unsigned HOLD_CYC    = 1,
  parameter int unsigned TIMEOUT_CYC = 64,
  parameter int unsigned RECOV_CYC   = 2
) (
  input  logic        clk_main,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic [14:0] cmd_addr,
  input  logic        cmd_upper,
  input  logic [7:0]  cmd_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        rsp_timeout,
  output logic        busy,
  output logic        OBJCS,
  output logic        PDS,
  output logic        NREAD,
  output logic [14:0] AB,
  output logic        nUDS,
  output logic [7:0]  DB_OUT,
  input  logic        ODTAC,
  input  logic [7:0]  DB_IN_k051960,
  input  logic [7:0]  DB_IN_k051937,
  input  logic        DBDIR_k051960,
  input  logic        DBDIR_k051937
);

  typedef enum logic [2:0] {StIdle, StSetup, StStrobe, StHold, StRecov} state_e;

  localparam logic [7:0] SetupLd   = 8'(SETUP_CYC);
  localparam logic [7:0] HoldLd    = 8'(HOLD_CYC);
  localparam logic [7:0] TimeoutLd = 8'(TIMEOUT_CYC);
  localparam logic [7:0] RecovLd   = 8'(RECOV_CYC);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        objcs_q, objcs_d;
  logic        pds_q, pds_d;
  logic        nread_q, nread_d;
  logic [14:0] ab_q, ab_d;
  logic        nuds_q, nuds_d;
  logic [7:0]  dbout_q, dbout_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [7:0]  rsp_rdata_q, rsp_rdata_d;
  logic        rsp_timeout_q, rsp_timeout_d;
  logic        go_recov;
  logic [7:0]  rd_mux;

  // k051937 takes priority when both chips claim the bus
  always_comb begin
    rd_mux = 8'hFF;
    if (DBDIR_k051937) begin
      rd_mux = DB_IN_k051937;
    end else if (DBDIR_k051960) begin
      rd_mux = DB_IN_k051960;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    objcs_d       = objcs_q;
    pds_d         = pds_q;
    nread_d       = nread_q;
    ab_d          = ab_q;
    nuds_d        = nuds_q;
    dbout_d       = dbout_q;
    rsp_valid_d   = 1'b0;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_timeout_d = rsp_timeout_q;
    go_recov      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          ab_d    = cmd_addr;
          nuds_d  = ~cmd_upper;
          nread_d = ~cmd_we;
          dbout_d = cmd_we ? cmd_wdata : 8'h00;
          objcs_d = 1'b0;
          cnt_d   = SetupLd;
          state_d = StSetup;
        end
      end
      StSetup: begin
        if (cnt_q <= 8'd1) begin
          pds_d   = 1'b1;
          cnt_d   = TimeoutLd;
          state_d = StStrobe;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      StStrobe: begin
        if (!ODTAC) begin
          cnt_d   = HoldLd;
          state_d = StHold;
        end else if (cnt_q <= 8'd1) begin
          go_recov      = 1'b1;
          rsp_timeout_d = 1'b1;
          rsp_rdata_d   = 8'hFF;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      StHold: begin
        if (cnt_q <= 8'd1) begin
          go_recov      = 1'b1;
          rsp_timeout_d = 1'b0;
          rsp_rdata_d   = nread_q ? rd_mux : 8'hFF;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      StRecov: begin
        if (cnt_q <= 8'd1) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (go_recov) begin
      pds_d       = 1'b0;
      objcs_d     = 1'b1;
      nread_d     = 1'b1;
      rsp_valid_d = 1'b1;
      cnt_d       = RecovLd;
      state_d     = StRecov;
    end
  end

  always_ff @(posedge clk_main) begin
    if (reset) begin
      state_q       <= StIdle;
      cnt_q         <= 8'd0;
      objcs_q       <= 1'b1;
      pds_q         <= 1'b0;
      nread_q       <= 1'b1;
      ab_q          <= 15'd0;
      nuds_q        <= 1'b1;
      dbout_q       <= 8'h00;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= 8'hFF;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      objcs_q       <= objcs_d;
      pds_q         <= pds_d;
      nread_q       <= nread_d;
      ab_q          <= ab_d;
      nuds_q        <= nuds_d;
      dbout_q       <= dbout_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign cmd_ready   = (state_q == StIdle);
  assign busy        = (state_q != StIdle);
  assign OBJCS       = objcs_q;
  assign PDS         = pds_q;
  assign NREAD       = nread_q;
  assign AB          = ab_q;
  assign nUDS        = nuds_q;
  assign DB_OUT      = dbout_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_obj_bus_master.sv
// Directed bench for obj_bus_master: writes, read-data muxing, timeout,
// back-to-back commands and mid-cycle reset, with inline assertions.
module tb_obj_bus_master;

  localparam int SetupCyc   = 2;
  localparam int HoldCyc    = 1;
  localparam int TimeoutCyc = 64;
  localparam int RecovCyc   = 2;

  logic        clk_main = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_we = 1'b0;
  logic [14:0] cmd_addr = '0;
  logic        cmd_upper = 1'b0;
  logic [7:0]  cmd_wdata = '0;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  logic        rsp_timeout;
  logic        busy;
  logic        OBJCS, PDS, NREAD, nUDS;
  logic [14:0] AB;
  logic [7:0]  DB_OUT;
  logic        ODTAC = 1'b1;
  logic [7:0]  DB_IN_k051960 = '0;
  logic [7:0]  DB_IN_k051937 = '0;
  logic        DBDIR_k051960 = 1'b0;
  logic        DBDIR_k051937 = 1'b0;

  int checks = 0;
  int errors = 0;

  obj_bus_master #(
    .SETUP_CYC  (SetupCyc),
    .HOLD_CYC   (HoldCyc),
    .TIMEOUT_CYC(TimeoutCyc),
    .RECOV_CYC  (RecovCyc)
  ) dut (
    .clk_main     (clk_main),
    .reset        (reset),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_we       (cmd_we),
    .cmd_addr     (cmd_addr),
    .cmd_upper    (cmd_upper),
    .cmd_wdata    (cmd_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_timeout  (rsp_timeout),
    .busy         (busy),
    .OBJCS        (OBJCS),
    .PDS          (PDS),
    .NREAD        (NREAD),
    .AB           (AB),
    .nUDS         (nUDS),
    .DB_OUT       (DB_OUT),
    .ODTAC        (ODTAC),
    .DB_IN_k051960(DB_IN_k051960),
    .DB_IN_k051937(DB_IN_k051937),
    .DBDIR_k051960(DBDIR_k051960),
    .DBDIR_k051937(DBDIR_k051937)
  );

  always #5 clk_main = ~clk_main;

  task automatic tick();
    @(posedge clk_main);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_objcs"}, OBJCS, 1'b1);
    chk({tag, "_pds"}, PDS, 1'b0);
    chk({tag, "_nread"}, NREAD, 1'b1);
    chk({tag, "_ab"}, AB, 15'd0);
    chk({tag, "_nuds"}, nUDS, 1'b1);
    chk({tag, "_dbout"}, DB_OUT, 8'h00);
    chk({tag, "_rspv"}, rsp_valid, 1'b0);
    chk({tag, "_rdata"}, rsp_rdata, 8'hFF);
    chk({tag, "_rspto"}, rsp_timeout, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_ready"}, cmd_ready, 1'b1);
  endtask

  // One command; odelay = cycles after PDS is seen high before ODTAC goes low
  // (negative: never acknowledge). lat = ticks from accept edge to rsp_valid.
  task automatic do_cmd(input string tag, input logic we, input logic [14:0] addr,
                        input logic up, input logic [7:0] wd, input int odelay,
                        output logic [7:0] rd, output logic to, output int lat);
    int pds_t;
    int nresp;
    int idle_t;
    int w;
    w = 0;
    while (!cmd_ready && w < 10) begin
      tick();
      w++;
    end
    chk({tag, "_ready"}, cmd_ready, 1'b1);
    cmd_we    = we;
    cmd_addr  = addr;
    cmd_upper = up;
    cmd_wdata = wd;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    chk({tag, "_busy"}, {busy, cmd_ready, OBJCS, PDS}, 4'b1000);
    pds_t  = -1;
    nresp  = 0;
    idle_t = -1;
    lat    = -1;
    rd     = 8'hxx;
    to     = 1'bx;
    for (int t = 0; t < 100; t++) begin
      if (PDS && pds_t < 0) begin
        pds_t = t;
        chk({tag, "_bus"}, {AB, nUDS, NREAD, DB_OUT, OBJCS},
            {addr, ~up, ~we, (we ? wd : 8'h00), 1'b0});
      end
      if (pds_t >= 0 && odelay >= 0 && t - pds_t == odelay) ODTAC = 1'b0;
      if (pds_t >= 0 && !PDS) ODTAC = 1'b1;
      if (rsp_valid) begin
        nresp++;
        lat = t;
        rd  = rsp_rdata;
        to  = rsp_timeout;
      end
      if (nresp > 0 && cmd_ready) begin
        idle_t = t;
        break;
      end
      tick();
    end
    ODTAC = 1'b1;
    chk({tag, "_pds_t"}, pds_t, SetupCyc);
    chk({tag, "_nresp"}, nresp, 1);
    chk({tag, "_recov"}, idle_t - lat, RecovCyc);
  endtask

  logic [7:0] rd;
  logic       to;
  int         lat;
  int         acc, nr, gap, mingap, bad_ready, npulse;
  logic       seen, rdy;

  initial begin
    tick();
    tick();
    chk_reset_outputs("por");
    reset = 1'b0;
    tick();
    chk_reset_outputs("idle");

    // Write, ODTAC 4 cycles after PDS
    do_cmd("wr", 1'b1, 15'h0010, 1'b1, 8'h5A, 4, rd, to, lat);
    chk("wr_rdata", rd, 8'hFF);
    chk("wr_to", to, 1'b0);
    chk("wr_lat", lat, SetupCyc + 4 + 1 + HoldCyc);

    // Reads: k051960 only, both (k051937 wins), neither
    DBDIR_k051960 = 1'b1;
    DB_IN_k051960 = 8'hC3;
    DB_IN_k051937 = 8'h3C;
    do_cmd("rd60", 1'b0, 15'h1234, 1'b0, 8'hAA, 0, rd, to, lat);
    chk("rd60_rdata", rd, 8'hC3);
    chk("rd60_to", to, 1'b0);
    chk("rd60_lat", lat, SetupCyc + 1 + HoldCyc);
    DBDIR_k051937 = 1'b1;
    do_cmd("rd37", 1'b0, 15'h7FFF, 1'b1, 8'h00, 1, rd, to, lat);
    chk("rd37_rdata", rd, 8'h3C);
    DBDIR_k051960 = 1'b0;
    DBDIR_k051937 = 1'b0;
    do_cmd("rdnone", 1'b0, 15'h0001, 1'b0, 8'h00, 0, rd, to, lat);
    chk("rdnone_rdata", rd, 8'hFF);

    // Timeout, then a late ODTAC must not produce a response
    DBDIR_k051960 = 1'b1;
    do_cmd("to", 1'b0, 15'h0200, 1'b0, 8'h00, -1, rd, to, lat);
    chk("to_flag", to, 1'b1);
    chk("to_rdata", rd, 8'hFF);
    chk("to_lat", lat, SetupCyc + TimeoutCyc);
    DBDIR_k051960 = 1'b0;
    npulse = 0;
    ODTAC = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (rsp_valid) npulse++;
    end
    ODTAC = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (rsp_valid) npulse++;
    end
    chk("late_odtac_rsp", npulse, 0);

    // cmd_valid held for three back-to-back reads with immediate ODTAC
    acc = 0; nr = 0; gap = 0; mingap = 99; bad_ready = 0; seen = 1'b0;
    cmd_we    = 1'b0;
    cmd_addr  = 15'h0040;
    cmd_valid = 1'b1;
    for (int c = 0; c < 40; c++) begin
      rdy = cmd_ready;
      tick();
      if (rdy && cmd_valid) begin
        acc++;
        cmd_addr = cmd_addr + 15'd1;
        if (acc == 3) cmd_valid = 1'b0;
      end
      ODTAC = ~PDS;
      if (rsp_valid) nr++;
      if (!OBJCS && cmd_ready) bad_ready++;
      if (cmd_ready === busy) bad_ready++;
      if (PDS) begin
        if (seen && gap > 0 && gap < mingap) mingap = gap;
        seen = 1'b1;
        gap  = 0;
      end else if (OBJCS) begin
        gap++;
      end
    end
    ODTAC = 1'b1;
    chk("b2b_acc", acc, 3);
    chk("b2b_rsp", nr, 3);
    chk("b2b_gap_ge2", (mingap >= 2 && mingap < 99), 1'b1);
    chk("b2b_ready", bad_ready, 0);

    // Reset during STROBE drops the command
    cmd_we    = 1'b1;
    cmd_addr  = 15'h0123;
    cmd_wdata = 8'h77;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    for (int i = 0; i < 10 && !PDS; i++) tick();
    chk("rst_pds_hi", PDS, 1'b1);
    reset = 1'b1;
    tick();
    chk_reset_outputs("rst_mid");
    reset = 1'b0;
    npulse = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (rsp_valid) npulse++;
    end
    chk("rst_no_rsp", npulse, 0);
    do_cmd("post", 1'b1, 15'h0055, 1'b0, 8'hA5, 0, rd, to, lat);
    chk("post_to", to, 1'b0);
    chk("post_lat", lat, SetupCyc + 1 + HoldCyc);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
